// File: rtl/klein_dec_ctrl.sv
// klein_dec_ctrl
// Sequencer for iterative KLEIN-64 block decryption. Holds the 64-bit cipher
// state and drives one external combinational inverse-round datapath
// (inverse MixNibbles, inverse RotateNibbles, inverse SubNibbles, key XOR).
// Round keys are fetched from an external key store in reverse order
// (NR+1 down to 1). Key NR+1 is used for the initial whitening XOR.
//
// Optional feature: define KLEIN_DEC_ABORT_EN to add the abort input.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid/in_ready     ciphertext handshake, cipher = ciphertext block
//   key_rd/key_addr       key-store read strobe and index (0 when idle)
//   key_data              key-store data, valid the cycle after key_rd
//   rnd_state/rnd_key     datapath inputs (state register, key_data)
//   rnd_text              datapath result
//   out_valid/out_ready   plaintext handshake, text = plaintext block
//   busy                  high whenever the controller is not IDLE
//   abort                 (KLEIN_DEC_ABORT_EN only) drop the block in flight
module klein_dec_ctrl #(
    parameter int NR = 12,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   cipher,
    output logic          key_rd,
    output logic [AW-1:0] key_addr,
    input  logic [63:0]   key_data,
    output logic [63:0]   rnd_state,
    output logic [63:0]   rnd_key,
    input  logic [63:0]   rnd_text,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef KLEIN_DEC_ABORT_EN
    input  logic          abort,
`endif
    output logic [63:0]   text,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WHITEN = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [AW-1:0] KEY_LAST = AW'(NR + 1);
    localparam logic [AW-1:0] KEY_NR   = AW'(NR);
    localparam logic [AW-1:0] ONE      = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic [63:0]   sreg_q, sreg_d;
    logic [63:0]   cipher_q, cipher_d;
    logic [63:0]   text_q, text_d;
    logic          out_valid_q, out_valid_d;
    logic          abort_w;
    logic          accept;

`ifdef KLEIN_DEC_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Abort only blocks the retire-and-accept path out of DONE; an abort
    // seen in IDLE is ignored, so a concurrent accept there still happens.
    assign in_ready = (state_q == IDLE) ||
                      ((state_q == DONE) && out_ready && !abort_w);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        sreg_d      = sreg_q;
        cipher_d    = cipher_q;
        text_d      = text_q;
        out_valid_d = out_valid_q;
        key_rd      = 1'b0;
        key_addr    = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cipher_d = cipher;
                    key_rd   = 1'b1;
                    key_addr = KEY_LAST;
                    state_d  = WHITEN;
                end
            end
            WHITEN: begin
                sreg_d   = cipher_q ^ key_data;
                key_rd   = 1'b1;
                key_addr = KEY_NR;
                rcnt_d   = KEY_NR;
                state_d  = ROUND;
            end
            ROUND: begin
                // key_data currently holds key index rcnt_q
                sreg_d = rnd_text;
                if (rcnt_q > ONE) begin
                    key_rd   = 1'b1;
                    key_addr = rcnt_q - ONE;
                    rcnt_d   = rcnt_q - ONE;
                end else begin
                    text_d      = rnd_text;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        // retire and start the next block in one cycle
                        cipher_d = cipher;
                        key_rd   = 1'b1;
                        key_addr = KEY_LAST;
                        state_d  = WHITEN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_w && (state_q != IDLE)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            rcnt_d      = '0;
            key_rd      = 1'b0;
            key_addr    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rcnt_q      <= '0;
            sreg_q      <= '0;
            cipher_q    <= '0;
            text_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            sreg_q      <= sreg_d;
            cipher_q    <= cipher_d;
            text_q      <= text_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign rnd_state = sreg_q;
    assign rnd_key   = key_data;
    assign text      = text_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_klein_dec_ctrl.sv
// tb_klein_dec_ctrl
// Bench for klein_dec_ctrl: provides a KLEIN-64 key store (one-cycle read
// latency) and the combinational inverse-round datapath, and compares the
// controller's plaintext against a whole-block KLEIN-64 decryption model.
// Define KLEIN_DEC_ABORT_EN to also exercise the abort input.
module tb_klein_dec_ctrl;
    localparam int NR = 12;
    localparam int AW = 4;
    localparam logic [63:0] SBOX = 64'h74A91FB0C3268ED5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   cipher;
    logic          key_rd;
    logic [AW-1:0] key_addr;
    logic [63:0]   key_data;
    logic [63:0]   rnd_state;
    logic [63:0]   rnd_key;
    logic [63:0]   rnd_text;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   text;
    logic          busy;
`ifdef KLEIN_DEC_ABORT_EN
    logic          abort;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] ks [0:(1<<AW)-1];
    logic [63:0] last_text;

    klein_dec_ctrl #(.NR(NR), .AW(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .cipher(cipher),
        .key_rd(key_rd),
        .key_addr(key_addr),
        .key_data(key_data),
        .rnd_state(rnd_state),
        .rnd_key(rnd_key),
        .rnd_text(rnd_text),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef KLEIN_DEC_ABORT_EN
        .abort(abort),
`endif
        .text(text),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- KLEIN-64 primitives ----------------
    function automatic logic [3:0] sb(input logic [3:0] x);
        return SBOX[60 - 4*int'(x) +: 4];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] c0, c1, c2, c3;
        c0 = c[31:24]; c1 = c[23:16]; c2 = c[15:8]; c3 = c[7:0];
        return {gmul(c0,4'd14) ^ gmul(c1,4'd11) ^ gmul(c2,4'd13) ^ gmul(c3,4'd9),
                gmul(c0,4'd9)  ^ gmul(c1,4'd14) ^ gmul(c2,4'd11) ^ gmul(c3,4'd13),
                gmul(c0,4'd13) ^ gmul(c1,4'd9)  ^ gmul(c2,4'd14) ^ gmul(c3,4'd11),
                gmul(c0,4'd11) ^ gmul(c1,4'd13) ^ gmul(c2,4'd9)  ^ gmul(c3,4'd14)};
    endfunction

    function automatic logic [63:0] inv_round(input logic [63:0] s, input logic [63:0] k);
        logic [63:0] m, r, u;
        m = {inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
        r = {m[15:0], m[63:16]};
        for (int j = 0; j < 16; j++) u[4*j +: 4] = sb(r[4*j +: 4]);
        return u ^ k;
    endfunction

    function automatic logic [63:0] next_key(input logic [63:0] sk, input int i);
        logic [31:0] a, b, na, nb;
        a  = {sk[55:32], sk[63:56]};
        b  = {sk[23:0],  sk[31:24]};
        na = b;
        nb = a ^ b;
        na[15:8] = na[15:8] ^ 8'(i);
        for (int j = 2; j < 6; j++) nb[4*j +: 4] = sb(nb[4*j +: 4]);
        return {na, nb};
    endfunction

    task automatic load_keys(input logic [63:0] k);
        for (int i = 0; i < (1<<AW); i++) ks[i] = 64'h0;
        ks[1] = k;
        for (int i = 1; i <= NR; i++) ks[i+1] = next_key(ks[i], i);
    endtask

    // Whole-block reference: whitening with key NR+1, then rounds NR..1.
    function automatic logic [63:0] model_dec(input logic [63:0] c);
        logic [63:0] s;
        s = c ^ ks[NR+1];
        for (int r = NR; r >= 1; r--) s = inv_round(s, ks[r]);
        return s;
    endfunction

    // ---------------- environment ----------------
    always @(posedge clk) if (key_rd) key_data <= ks[key_addr];
    always_comb rnd_text = inv_round(rnd_state, rnd_key);

    // Offer one block for one cycle; returns at the negedge one cycle after accept.
    task automatic start_block(input logic [63:0] c);
        @(negedge clk);
        in_valid = 1'b1;
        cipher   = c;
        @(negedge clk);
        in_valid = 1'b0;
        cipher   = {$urandom, $urandom};
    endtask

    // Latency in cycles from accept until out_valid is seen (-1 on timeout).
    task automatic wait_out(output int lat);
        lat = -1;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            if (out_valid === 1'b1) lat = n;
            else @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cipher = 64'h0;
`ifdef KLEIN_DEC_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (key_rd !== 1'b0) begin n_fail++; $display("FAIL reset_key_rd: got %b want 0", key_rd); end
        n_checks++; if (key_addr !== '0) begin n_fail++; $display("FAIL reset_key_addr: got %0d want 0", key_addr); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (text !== 64'h0) begin n_fail++; $display("FAIL reset_text: got %h want 0", text); end
        n_checks++; if (rnd_state !== 64'h0) begin n_fail++; $display("FAIL reset_state: got %h want 0", rnd_state); end
        rst_n = 1'b1;
        last_text = 64'h0;
    endtask

    task automatic test_known_vector();
        logic [AW-1:0] addrs[$];
        logic          rd_done;
        logic [63:0]   got;
        int            lat;
        logic          seq_ok;
        load_keys(64'h0);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; cipher = 64'hCDC0B51F14722BBE;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL kv_in_ready: got %b want 1", in_ready); end
        if (key_rd) addrs.push_back(key_addr);
        lat = -1; rd_done = 1'b1; got = 64'h0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (n == 1) begin in_valid = 1'b0; cipher = {$urandom, $urandom}; end
            #1;
            if (out_valid) begin lat = n; rd_done = key_rd; got = text; end
            else if (key_rd) addrs.push_back(key_addr);
        end
        n_checks++; if (lat != 14) begin n_fail++; $display("FAIL kv_latency: got %0d want 14", lat); end
        n_checks++; if (got !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL kv_text: got %h want ffffffffffffffff", got); end
        n_checks++; if (got !== model_dec(64'hCDC0B51F14722BBE)) begin n_fail++; $display("FAIL kv_model: got %h want %h", got, model_dec(64'hCDC0B51F14722BBE)); end
        n_checks++; if (rd_done !== 1'b0) begin n_fail++; $display("FAIL kv_key_rd_done: got %b want 0", rd_done); end
        n_checks++; if (addrs.size() != NR + 1) begin n_fail++; $display("FAIL kv_addr_count: got %0d want %0d", addrs.size(), NR + 1); end
        seq_ok = 1'b1;
        for (int i = 0; i < addrs.size(); i++) if (int'(addrs[i]) != NR + 1 - i) seq_ok = 1'b0;
        n_checks++; if (seq_ok !== 1'b1) begin n_fail++; $display("FAIL kv_addr_seq: got first=%0d size=%0d want 13 down to 1", addrs.size() > 0 ? int'(addrs[0]) : -1, addrs.size()); end
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kv_idle_busy: got %b want 0", busy); end
        n_checks++; if (key_rd !== 1'b0 || key_addr !== '0) begin n_fail++; $display("FAIL kv_idle_key: got rd=%b addr=%0d want 0/0", key_rd, key_addr); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kv_idle_out_valid: got %b want 0", out_valid); end
        out_ready = 1'b0;
        last_text = 64'hFFFFFFFFFFFFFFFF;
    endtask

    task automatic test_stall();
        logic [63:0] c, exp;
        int lat;
        c = {$urandom, $urandom}; exp = model_dec(c);
        out_ready = 1'b0;
        start_block(c);
        wait_out(lat);
        n_checks++; if (lat != 14) begin n_fail++; $display("FAIL stall_latency: got %0d want 14", lat); end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; cipher = {$urandom, $urandom};
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, in_ready); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid[%0d]: got %b want 1", k, out_valid); end
            n_checks++; if (text !== exp) begin n_fail++; $display("FAIL stall_text[%0d]: got %h want %h", k, text, exp); end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_idle: got busy=%b ov=%b want 0/0", busy, out_valid); end
        out_ready = 1'b0;
        last_text = exp;
    endtask

    task automatic test_back_to_back();
        logic [63:0] c0, c1, e0, e1;
        logic [63:0] txt [4];
        int t_out [4];
        int acc_t [4];
        int acc_n, outs;
        c0 = {$urandom, $urandom}; c1 = {$urandom, $urandom};
        e0 = model_dec(c0); e1 = model_dec(c1);
        acc_n = 0; outs = 0;
        for (int i = 0; i < 4; i++) begin txt[i] = 64'h0; t_out[i] = -1; acc_t[i] = -1; end
        @(negedge clk);
        in_valid = 1'b1; cipher = c0; out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (out_valid && outs < 4) begin t_out[outs] = n; txt[outs] = text; outs++; end
            if (in_valid && in_ready && acc_n < 4) begin acc_t[acc_n] = n; acc_n++; end
            @(negedge clk);
            if (acc_n == 1) cipher = c1;
            if (acc_n >= 2) in_valid = 1'b0;
        end
        n_checks++; if (outs != 2) begin n_fail++; $display("FAIL b2b_out_count: got %0d want 2", outs); end
        n_checks++; if (acc_t[1] != 14) begin n_fail++; $display("FAIL b2b_second_accept: got %0d want 14", acc_t[1]); end
        n_checks++; if (t_out[0] != 14 || t_out[1] != 28) begin n_fail++; $display("FAIL b2b_out_times: got %0d,%0d want 14,28", t_out[0], t_out[1]); end
        n_checks++; if (txt[0] !== e0) begin n_fail++; $display("FAIL b2b_text0: got %h want %h", txt[0], e0); end
        n_checks++; if (txt[1] !== e1) begin n_fail++; $display("FAIL b2b_text1: got %h want %h", txt[1], e1); end
        out_ready = 1'b0;
        last_text = e1;
    endtask

    task automatic test_reset_mid();
        logic [63:0] c0, c1, exp;
        int seen, lat;
        c0 = {$urandom, $urandom};
        out_ready = 1'b1;
        start_block(c0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got busy=%b ov=%b want 0/0", busy, out_valid); end
        n_checks++; if (text !== 64'h0 || rnd_state !== 64'h0) begin n_fail++; $display("FAIL rstmid_regs: got text=%h state=%h want 0/0", text, rnd_state); end
        seen = 0;
        repeat (20) begin @(negedge clk); if (out_valid) seen++; end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_output: got %0d outputs want 0", seen); end
        c1 = {$urandom, $urandom}; exp = model_dec(c1);
        start_block(c1);
        wait_out(lat);
        n_checks++; if (lat != 14) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 14", lat); end
        n_checks++; if (text !== exp) begin n_fail++; $display("FAIL rstmid_text: got %h want %h", text, exp); end
        @(negedge clk);
        out_ready = 1'b0;
        last_text = exp;
    endtask

    task automatic test_random_blocks();
        logic [63:0] c, exp;
        int lat, k;
        load_keys({$urandom, $urandom});
        for (int b = 0; b < 6; b++) begin
            c = {$urandom, $urandom}; exp = model_dec(c);
            out_ready = 1'b0;
            start_block(c);
            wait_out(lat);
            n_checks++; if (lat != 14) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 14", b, lat); end
            n_checks++; if (text !== exp) begin n_fail++; $display("FAIL rand_text[%0d]: got %h want %h", b, text, exp); end
            k = int'($urandom_range(0, 3));
            repeat (k) @(negedge clk);
            n_checks++; if (text !== exp || out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_hold[%0d]: got %h ov=%b want %h ov=1", b, text, out_valid, exp); end
            out_ready = 1'b1;
            @(negedge clk);
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_idle[%0d]: got busy=%b want 0", b, busy); end
            out_ready = 1'b0;
            last_text = exp;
        end
    endtask

`ifdef KLEIN_DEC_ABORT_EN
    task automatic test_abort();
        logic [63:0] c, exp;
        int seen, lat;
        c = {$urandom, $urandom};
        out_ready = 1'b0;
        start_block(c);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b ov=%b want 0/0", busy, out_valid); end
        n_checks++; if (key_rd !== 1'b0) begin n_fail++; $display("FAIL abort_key_rd: got %b want 0", key_rd); end
        n_checks++; if (text !== last_text) begin n_fail++; $display("FAIL abort_text_kept: got %h want %h", text, last_text); end
        seen = 0;
        repeat (20) begin @(negedge clk); if (out_valid) seen++; end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_output: got %0d outputs want 0", seen); end
        c = {$urandom, $urandom}; exp = model_dec(c);
        abort = 1'b1; in_valid = 1'b1; cipher = c;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle_ready: got %b want 1", in_ready); end
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0; cipher = {$urandom, $urandom};
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_idle_accept: got busy=%b want 1", busy); end
        wait_out(lat);
        n_checks++; if (lat != 14) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 14", lat); end
        n_checks++; if (text !== exp) begin n_fail++; $display("FAIL abort_next_text: got %h want %h", text, exp); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        last_text = exp;
    endtask
`endif

    initial begin
        test_reset();
        test_known_vector();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random_blocks();
`ifdef KLEIN_DEC_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
